// File: rtl/exec_sched_ctrl.sv
// rtl/exec_sched_ctrl.sv - execute-stage issue scheduler and ePipe sequencer
//
// Accepts one decoded instruction at a time, sequences vector beats, holds
// memory ops until acknowledged or timed out, resolves conditional jumps and
// drives the ePipe load/flush controls. An end instruction halts until reset.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   issue_valid_i / issue_ready_o     decode handshake
//   en_alu_int_i, en_alu_vec_i, en_mem_i, en_jump_i, en_swap_i,
//   flag_end_i, flag_nop_i, mem_read_i, mem_write_i, cond_i,
//   jump_addr_i, alu_flags_i          decoded instruction fields
//   mem_ack_i                         memory completion
//   pipe_en_o, pipe_flush_o           ePipe load / flush
//   vec_beat_o, vec_last_o, lane_idx_o vector beat sequencing
//   mem_req_o, mem_we_o               memory request level and direction
//   jump_take_o, jump_addr_o          taken-jump pulse and target
//   flags_o, halted_o, mem_err_o      architectural flags and sticky status
module exec_sched_ctrl #(
  parameter int VECT_LANES  = 3,
  parameter int VECT_SIZE   = 8,
  parameter int JADDR_W     = 10,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          issue_valid_i,
  output logic                          issue_ready_o,
  input  logic                          en_alu_int_i,
  input  logic                          en_alu_vec_i,
  input  logic                          en_mem_i,
  input  logic                          en_jump_i,
  input  logic                          en_swap_i,
  input  logic                          flag_end_i,
  input  logic                          flag_nop_i,
  input  logic                          mem_read_i,
  input  logic                          mem_write_i,
  input  logic [1:0]                    cond_i,
  input  logic [JADDR_W-1:0]            jump_addr_i,
  input  logic [3:0]                    alu_flags_i,
  input  logic                          mem_ack_i,
  output logic                          pipe_en_o,
  output logic                          pipe_flush_o,
  output logic                          vec_beat_o,
  output logic                          vec_last_o,
  output logic [$clog2(VECT_SIZE)-1:0]  lane_idx_o,
  output logic                          mem_req_o,
  output logic                          mem_we_o,
  output logic                          jump_take_o,
  output logic [JADDR_W-1:0]            jump_addr_o,
  output logic [3:0]                    flags_o,
  output logic                          halted_o,
  output logic                          mem_err_o
);

  localparam int BEATS  = (VECT_SIZE + VECT_LANES - 1) / VECT_LANES;
  localparam int LIDX_W = $clog2(VECT_SIZE);
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int TMR_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_VEC      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_END, OP_NOP, OP_JUMP, OP_MEM, OP_VEC, OP_INT
  } op_class_t;

  state_t              state_q, state_d;
  op_class_t           op_class;
  logic                accept;
  logic                jump_cond;
  logic [BCNT_W-1:0]   beat_q, beat_d, beat_nxt;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                pipe_en_d, pipe_flush_d, vec_beat_d, vec_last_d;
  logic [LIDX_W-1:0]   lane_idx_d;
  logic                mem_req_d, mem_we_d, jump_take_d, halted_d, mem_err_d;
  logic [JADDR_W-1:0]  jump_addr_d;
  logic [3:0]          flags_d;

  // Direction comes from mem_write_i alone; a read-only op is simply we=0.
  wire unused_inputs = &{1'b0, mem_read_i};

  assign issue_ready_o = (state_q == S_IDLE);
  assign accept        = issue_valid_i & issue_ready_o;
  assign beat_nxt      = beat_q + BCNT_W'(1);

  // Decode priority: end > nop > jump > mem > vec > int/swap; nothing set acts as nop.
  always_comb begin
    op_class = OP_NOP;
    if (flag_end_i)                      op_class = OP_END;
    else if (flag_nop_i)                 op_class = OP_NOP;
    else if (en_jump_i)                  op_class = OP_JUMP;
    else if (en_mem_i)                   op_class = OP_MEM;
    else if (en_alu_vec_i)               op_class = OP_VEC;
    else if (en_alu_int_i | en_swap_i)   op_class = OP_INT;
  end

  // Condition uses the flags register as it stands, never a same-cycle update.
  always_comb begin
    jump_cond = 1'b1;
    case (cond_i)
      2'b00:   jump_cond = 1'b1;
      2'b01:   jump_cond = flags_o[2];
      2'b10:   jump_cond = ~flags_o[2];
      default: jump_cond = flags_o[3];
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_class)
            OP_END:  state_d = S_HALT;
            OP_MEM:  state_d = S_MEM_WAIT;
            OP_VEC:  state_d = S_VEC;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_VEC: begin
        if (beat_q == BCNT_W'(BEATS - 1)) state_d = S_IDLE;
      end
      S_MEM_WAIT: begin
        if (mem_ack_i || timer_q == TMR_W'(MEM_TIMEOUT - 1)) state_d = S_IDLE;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Output logic: next values of the registered outputs and counters
  always_comb begin
    pipe_en_d    = 1'b0;
    pipe_flush_d = 1'b0;
    vec_beat_d   = 1'b0;
    vec_last_d   = 1'b0;
    lane_idx_d   = '0;
    mem_req_d    = 1'b0;
    mem_we_d     = 1'b0;
    jump_take_d  = 1'b0;
    jump_addr_d  = jump_addr_o;
    flags_d      = flags_o;
    halted_d     = halted_o;
    mem_err_d    = mem_err_o;
    beat_d       = '0;
    timer_d      = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_class)
            OP_END: halted_d = 1'b1;
            OP_INT: begin
              pipe_en_d = 1'b1;
              if (en_alu_int_i) flags_d = alu_flags_i;
            end
            OP_JUMP: begin
              if (jump_cond) begin
                jump_take_d  = 1'b1;
                pipe_flush_d = 1'b1;
                jump_addr_d  = jump_addr_i;
              end
            end
            OP_MEM: begin
              mem_req_d = 1'b1;
              mem_we_d  = mem_write_i;
            end
            OP_VEC: begin
              vec_beat_d = 1'b1;
              // A single-beat vector is its own last beat.
              vec_last_d = (BEATS == 1);
              pipe_en_d  = (BEATS == 1);
            end
            default: ;
          endcase
        end
      end
      S_VEC: begin
        if (beat_q != BCNT_W'(BEATS - 1)) begin
          beat_d     = beat_nxt;
          vec_beat_d = 1'b1;
          lane_idx_d = lane_idx_o + LIDX_W'(VECT_LANES);
          vec_last_d = (beat_nxt == BCNT_W'(BEATS - 1));
          pipe_en_d  = (beat_nxt == BCNT_W'(BEATS - 1));
        end
      end
      S_MEM_WAIT: begin
        // An ack on the final timeout cycle still counts as success.
        if (mem_ack_i) begin
          pipe_en_d = 1'b1;
        end else if (timer_q == TMR_W'(MEM_TIMEOUT - 1)) begin
          mem_err_d    = 1'b1;
          pipe_flush_d = 1'b1;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we_o;
          timer_d   = timer_q + TMR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pipe_en_o    <= 1'b0;
      pipe_flush_o <= 1'b0;
      vec_beat_o   <= 1'b0;
      vec_last_o   <= 1'b0;
      lane_idx_o   <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      jump_take_o  <= 1'b0;
      jump_addr_o  <= '0;
      flags_o      <= '0;
      halted_o     <= 1'b0;
      mem_err_o    <= 1'b0;
      beat_q       <= '0;
      timer_q      <= '0;
    end else begin
      pipe_en_o    <= pipe_en_d;
      pipe_flush_o <= pipe_flush_d;
      vec_beat_o   <= vec_beat_d;
      vec_last_o   <= vec_last_d;
      lane_idx_o   <= lane_idx_d;
      mem_req_o    <= mem_req_d;
      mem_we_o     <= mem_we_d;
      jump_take_o  <= jump_take_d;
      jump_addr_o  <= jump_addr_d;
      flags_o      <= flags_d;
      halted_o     <= halted_d;
      mem_err_o    <= mem_err_d;
      beat_q       <= beat_d;
      timer_q      <= timer_d;
    end
  end

endmodule

// File: tb/tb_exec_sched_ctrl.sv
// tb/tb_exec_sched_ctrl.sv - self-checking bench for exec_sched_ctrl
module tb_exec_sched_ctrl;

  localparam int LANES  = 3;
  localparam int VSIZE  = 8;
  localparam int JW     = 10;
  localparam int TO     = 15;
  localparam int NBEATS = (VSIZE + LANES - 1) / LANES;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          issue_valid_i = 1'b0;
  logic          issue_ready_o;
  logic          en_alu_int_i = 1'b0, en_alu_vec_i = 1'b0, en_mem_i = 1'b0;
  logic          en_jump_i = 1'b0, en_swap_i = 1'b0, flag_end_i = 1'b0, flag_nop_i = 1'b0;
  logic          mem_read_i = 1'b0, mem_write_i = 1'b0, mem_ack_i = 1'b0;
  logic [1:0]    cond_i = 2'b00;
  logic [JW-1:0] jump_addr_i = '0;
  logic [3:0]    alu_flags_i = 4'h0;
  logic          pipe_en_o, pipe_flush_o, vec_beat_o, vec_last_o;
  logic [2:0]    lane_idx_o;
  logic          mem_req_o, mem_we_o, jump_take_o;
  logic [JW-1:0] jump_addr_o;
  logic [3:0]    flags_o;
  logic          halted_o, mem_err_o;

  always #5 clk_i = ~clk_i;

  exec_sched_ctrl #(
    .VECT_LANES(LANES), .VECT_SIZE(VSIZE), .JADDR_W(JW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .en_alu_int_i(en_alu_int_i), .en_alu_vec_i(en_alu_vec_i), .en_mem_i(en_mem_i),
    .en_jump_i(en_jump_i), .en_swap_i(en_swap_i), .flag_end_i(flag_end_i),
    .flag_nop_i(flag_nop_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .cond_i(cond_i), .jump_addr_i(jump_addr_i), .alu_flags_i(alu_flags_i),
    .mem_ack_i(mem_ack_i), .pipe_en_o(pipe_en_o), .pipe_flush_o(pipe_flush_o),
    .vec_beat_o(vec_beat_o), .vec_last_o(vec_last_o), .lane_idx_o(lane_idx_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .jump_take_o(jump_take_o),
    .jump_addr_o(jump_addr_o), .flags_o(flags_o), .halted_o(halted_o),
    .mem_err_o(mem_err_o)
  );

  typedef struct {
    logic e_int, e_vec, e_mem, e_jmp, e_swp, f_end, f_nop, rd, wr;
    logic [1:0]    cond;
    logic [JW-1:0] addr;
    logic [3:0]    fl;
    int            lat;
  } op_t;

  typedef enum {C_END, C_NOP, C_JMP, C_MEM, C_VEC, C_INT} cls_t;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Architectural model state
  logic [3:0]    m_flags  = 4'h0;
  logic [JW-1:0] m_jaddr  = '0;
  logic          m_err    = 1'b0;
  logic          m_halted = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctl vector: {ready, pipe_en, flush, beat, last, lane[2:0], req, take, halted, err}
  task automatic expect_out(input string tag, input logic rdy, input logic pen, input logic fl,
                            input logic vb, input logic vl, input logic [2:0] lane,
                            input logic req, input logic tk);
    chk({tag, ":ctl"},
        {20'd0, issue_ready_o, pipe_en_o, pipe_flush_o, vec_beat_o, vec_last_o, lane_idx_o,
         mem_req_o, jump_take_o, halted_o, mem_err_o},
        {20'd0, rdy, pen, fl, vb, vl, lane, req, tk, m_halted, m_err});
    chk({tag, ":flags"}, 32'(flags_o), 32'(m_flags));
    chk({tag, ":jaddr"}, 32'(jump_addr_o), 32'(m_jaddr));
  endtask

  function automatic cls_t classify(input op_t o);
    if (o.f_end) return C_END;
    if (o.f_nop) return C_NOP;
    if (o.e_jmp) return C_JMP;
    if (o.e_mem) return C_MEM;
    if (o.e_vec) return C_VEC;
    if (o.e_int || o.e_swp) return C_INT;
    return C_NOP;
  endfunction

  function automatic logic jump_taken(input logic [1:0] cond, input logic [3:0] fl);
    case (cond)
      2'b00:   return 1'b1;
      2'b01:   return fl[2];
      2'b10:   return !fl[2];
      default: return fl[3];
    endcase
  endfunction

  // Decode fields carry junk whenever valid is low.
  task automatic junk_inputs();
    issue_valid_i = 1'b0;
    {en_alu_int_i, en_alu_vec_i, en_mem_i, en_jump_i, en_swap_i,
     flag_end_i, flag_nop_i, mem_read_i, mem_write_i} = 9'($urandom);
    cond_i      = 2'($urandom);
    jump_addr_i = JW'($urandom);
    alu_flags_i = 4'($urandom);
    mem_ack_i   = 1'b0;
  endtask

  task automatic present(input op_t o);
    chk("ready_at_issue", 32'(issue_ready_o), 32'd1);
    issue_valid_i = 1'b1;
    en_alu_int_i = o.e_int; en_alu_vec_i = o.e_vec; en_mem_i = o.e_mem;
    en_jump_i = o.e_jmp; en_swap_i = o.e_swp; flag_end_i = o.f_end; flag_nop_i = o.f_nop;
    mem_read_i = o.rd; mem_write_i = o.wr; cond_i = o.cond;
    jump_addr_i = o.addr; alu_flags_i = o.fl;
    mem_ack_i = 1'($urandom);
    @(negedge clk_i);
    junk_inputs();
  endtask

  task automatic do_op(input op_t o);
    cls_t c;
    logic tk;
    int   n;
    c = classify(o);
    case (c)
      C_NOP: begin
        present(o);
        expect_out("nop", 1, 0, 0, 0, 0, 3'd0, 0, 0);
      end
      C_INT: begin
        present(o);
        if (o.e_int) m_flags = o.fl;
        expect_out("int", 1, 1, 0, 0, 0, 3'd0, 0, 0);
      end
      C_JMP: begin
        tk = jump_taken(o.cond, m_flags);
        present(o);
        if (tk) m_jaddr = o.addr;
        expect_out("jump", 1, 0, tk, 0, 0, 3'd0, 0, tk);
      end
      C_VEC: begin
        present(o);
        for (int b = 0; b < NBEATS; b++) begin
          expect_out("vec_beat", 0, (b == NBEATS - 1), 0, 1, (b == NBEATS - 1),
                     3'(b * LANES), 0, 0);
          mem_ack_i = 1'($urandom);
          @(negedge clk_i);
        end
        mem_ack_i = 1'b0;
        expect_out("vec_done", 1, 0, 0, 0, 0, 3'd0, 0, 0);
      end
      C_MEM: begin
        present(o);
        n = (o.lat <= TO) ? o.lat : TO;
        for (int k = 1; k <= n; k++) begin
          expect_out("mem_wait", 0, 0, 0, 0, 0, 3'd0, 1, 0);
          chk("mem_we", 32'(mem_we_o), 32'(o.wr));
          if (k == o.lat) mem_ack_i = 1'b1;
          @(negedge clk_i);
          mem_ack_i = 1'b0;
        end
        if (o.lat <= TO) begin
          expect_out("mem_ack", 1, 1, 0, 0, 0, 3'd0, 0, 0);
        end else begin
          m_err = 1'b1;
          expect_out("mem_timeout", 1, 0, 1, 0, 0, 3'd0, 0, 0);
        end
      end
      default: begin
        present(o);
        m_halted = 1'b1;
        expect_out("halt", 0, 0, 0, 0, 0, 3'd0, 0, 0);
        for (int k = 0; k < 6; k++) begin
          junk_inputs();
          issue_valid_i = 1'b1;
          @(negedge clk_i);
          expect_out("halt_hold", 0, 0, 0, 0, 0, 3'd0, 0, 0);
        end
        junk_inputs();
      end
    endcase
  endtask

  // Asserts reset between edges so the checks prove it acts without a clock.
  task automatic apply_reset(input string tag);
    junk_inputs();
    #2;
    rst_i = 1'b0;
    m_flags = 4'h0; m_jaddr = '0; m_err = 1'b0; m_halted = 1'b0;
    #1;
    expect_out(tag, 1, 0, 0, 0, 0, 3'd0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  function automatic op_t blank();
    op_t o;
    o = '{default: 0};
    return o;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    op_t o;
    junk_inputs();
    rst_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    expect_out("reset", 1, 0, 0, 0, 0, 3'd0, 0, 0);
    rst_i = 1'b1;

    // int op loads flags, back-to-back swap does not
    o = blank(); o.e_int = 1; o.fl = 4'b0100; do_op(o);
    o = blank(); o.e_swp = 1; o.fl = 4'b1011; do_op(o);

    // vector op: three beats
    o = blank(); o.e_vec = 1; do_op(o);

    // jumps on Z=1
    o = blank(); o.e_jmp = 1; o.cond = 2'b01; o.addr = 10'h155; do_op(o);
    o = blank(); o.e_jmp = 1; o.cond = 2'b10; o.addr = 10'h2aa; do_op(o);
    o = blank(); o.e_jmp = 1; o.cond = 2'b11; o.addr = 10'h0f0; do_op(o);

    // memory: ack after 4, ack on timeout cycle, timeout with read+write
    o = blank(); o.e_mem = 1; o.wr = 1; o.lat = 4; do_op(o);
    o = blank(); o.e_mem = 1; o.rd = 1; o.lat = TO; do_op(o);
    o = blank(); o.e_mem = 1; o.rd = 1; o.wr = 1; o.lat = TO + 1; do_op(o);

    // priority: nop beats jump, no enables is a nop, jump beats mem
    o = blank(); o.f_nop = 1; o.e_jmp = 1; o.e_int = 1; o.fl = 4'hf; do_op(o);
    o = blank(); o.fl = 4'hf; do_op(o);
    o = blank(); o.e_jmp = 1; o.e_mem = 1; o.cond = 2'b00; o.addr = 10'h3c3; do_op(o);

    // randomized mix
    for (int i = 0; i < 150; i++) begin
      o = blank();
      o.e_int = ($urandom_range(0, 3) == 0);
      o.e_vec = ($urandom_range(0, 4) == 0);
      o.e_mem = ($urandom_range(0, 4) == 0);
      o.e_jmp = ($urandom_range(0, 4) == 0);
      o.e_swp = ($urandom_range(0, 4) == 0);
      o.f_nop = ($urandom_range(0, 7) == 0);
      o.rd    = 1'($urandom);
      o.wr    = 1'($urandom);
      o.cond  = 2'($urandom);
      o.addr  = JW'($urandom);
      o.fl    = 4'($urandom);
      o.lat   = $urandom_range(1, TO + 3);
      do_op(o);
    end

    // end instruction, valid held high while halted
    o = blank(); o.f_end = 1; o.e_int = 1; o.fl = 4'h5; do_op(o);
    apply_reset("rst_from_halt");

    // reset in the middle of a vector op
    o = blank(); o.e_int = 1; o.fl = 4'b1100; do_op(o);
    o = blank(); o.e_vec = 1;
    present(o);
    expect_out("vec_pre_rst", 0, 0, 0, 1, 0, 3'd0, 0, 0);
    @(negedge clk_i);
    apply_reset("rst_mid_vec");

    // reset while a memory request is pending
    o = blank(); o.e_mem = 1; o.wr = 1;
    present(o);
    expect_out("mem_pre_rst", 0, 0, 0, 0, 0, 3'd0, 1, 0);
    apply_reset("rst_mid_mem");

    o = blank(); o.e_int = 1; o.fl = 4'b0011; do_op(o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
